// File: rtl/wb_dma_copy.sv
// Single-channel Wishbone block-copy engine: a 4-word responder register port
// programs SRC/DST/LEN, and a classic initiator port moves one word at a time.
module wb_dma_copy #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = DW/8,
   parameter int LW = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_cyc,
   input  logic          i_stb,
   input  logic          i_we,
   input  logic [1:0]    i_addr,
   input  logic [DW-1:0] i_data,
   input  logic [SW-1:0] i_sel,
   output logic          o_ack,
   output logic [DW-1:0] o_data,
   output logic          o_err,
   output logic          o_mcyc,
   output logic          o_mstb,
   output logic          o_mwe,
   output logic [AW-1:0] o_maddr,
   output logic [DW-1:0] o_mdata,
   output logic [SW-1:0] o_msel,
   input  logic          i_mack,
   input  logic [DW-1:0] i_mdata,
   input  logic          i_merr,
   output logic          o_irq
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_GAP, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] len_dec;
   logic [DW-1:0] buf_q, buf_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          irq_en_q, irq_en_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          ack_q, ack_d;
   logic          busy;
   logic          reg_hit;
   logic          reg_wr;
   logic          bus_req;
   logic          unused_sel;

   // Byte selects are not honoured: the register port only takes full words.
   assign unused_sel = ^i_sel;

   assign busy    = (state_q != S_IDLE);
   assign reg_hit = i_cyc & i_stb & ~ack_q;
   assign reg_wr  = reg_hit & i_we;

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      buf_d    = buf_q;
      rdata_d  = rdata_q;
      irq_en_d = irq_en_q;
      done_d   = done_q;
      err_d    = err_q;
      ack_d    = reg_hit;
      len_dec  = len_q - LW'(1);

      if (reg_hit && !i_we) begin
         case (i_addr)
            2'd0:    rdata_d = DW'(src_q);
            2'd1:    rdata_d = DW'(dst_q);
            2'd2:    rdata_d = DW'(len_q);
            default: rdata_d = DW'({err_q, done_q, irq_en_q, busy});
         endcase
      end

      if (reg_wr) begin
         case (i_addr)
            2'd0: if (!busy) src_d = AW'(i_data);
            2'd1: if (!busy) dst_d = AW'(i_data);
            2'd2: if (!busy) len_d = i_data[LW-1:0];
            default: begin
               irq_en_d = i_data[1];
               // Clear is applied before start so clear+start behaves like a fresh start.
               if (i_data[2]) begin
                  done_d = 1'b0;
                  err_d  = 1'b0;
               end
               if (i_data[0] && !busy) begin
                  if (len_q == '0) begin
                     done_d = 1'b1;
                  end else begin
                     done_d  = 1'b0;
                     err_d   = 1'b0;
                     state_d = S_READ;
                  end
               end
            end
         endcase
      end

      case (state_q)
         S_READ: begin
            if (i_merr) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (i_mack) begin
               buf_d   = i_mdata;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (i_merr) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (i_mack) begin
               src_d   = src_q + AW'(1);
               dst_d   = dst_q + AW'(1);
               len_d   = len_dec;
               state_d = (len_dec == '0) ? S_DONE : S_GAP;
            end
         end
         S_GAP:   state_d = S_READ;
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         buf_q    <= '0;
         rdata_q  <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         buf_q    <= buf_d;
         rdata_q  <= rdata_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ack_q    <= ack_d;
      end
   end

   // Strobe is tied to cycle: classic single-beat transfers, held through wait states.
   assign bus_req = (state_q == S_READ) || (state_q == S_WRITE);
   assign o_mcyc  = bus_req;
   assign o_mstb  = bus_req;
   assign o_mwe   = (state_q == S_WRITE);
   assign o_maddr = (state_q == S_WRITE) ? dst_q : ((state_q == S_READ) ? src_q : '0);
   assign o_mdata = (state_q == S_WRITE) ? buf_q : '0;
   assign o_msel  = {SW{1'b1}};

   assign o_ack   = ack_q;
   assign o_data  = rdata_q;
   assign o_err   = 1'b0;
   assign o_irq   = irq_en_q & (done_q | err_q);

endmodule
